// File: rtl/sha256_msg_seq.sv
// ============================================================================
// Module   : sha256_msg_seq
// Brief    : Multi-block message sequencer for an iterative SHA-256 core;
//            chains the hash across blocks and returns the final digest.
//            Optional watchdog enabled with macro SHA256_SEQ_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_seq #(
    parameter logic [255:0] IV      = 256'h6A09E667BB67AE853C6EF372A54FF53A510E527F9B05688C1F83D9AB5BE0CD19,
    parameter int unsigned  TIMEOUT = 80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         busy,
    output logic [255:0] core_H_in,
    output logic [511:0] core_M_in,
    output logic         core_input_valid,
    input  logic [255:0] core_H_out,
    input  logic         core_output_valid
`ifdef SHA256_SEQ_WDOG_EN
    ,
    output logic         err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [255:0]   r_h;
    logic [511:0]   r_m;
    logic           r_last;
    logic           r_msg_active;
    logic [255:0]   r_dig;
    logic           w_accept;
    logic           w_core_done;

`ifdef SHA256_SEQ_WDOG_EN
    localparam int unsigned c_WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) + 1 : 2;
    logic [c_WDOG_W-1:0] r_wdog_cnt;
    logic                r_err;
    logic                w_timeout;
    assign err = r_err;
`else
    // TIMEOUT only matters with the watchdog; still reject nonsense values.
    if (TIMEOUT < 2) begin : g_timeout_check
        $error("sha256_msg_seq: TIMEOUT must be at least 2");
    end
`endif

    assign blk_ready        = (r_state == S_IDLE) && !rst;
    assign core_input_valid = (r_state == S_LOAD);
    assign core_H_in        = r_h;
    assign core_M_in        = r_m;
    assign dig_valid        = (r_state == S_DONE);
    assign dig_data         = r_dig;
    assign busy             = r_msg_active || (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_core_done = 1'b0;
`ifdef SHA256_SEQ_WDOG_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (blk_valid && blk_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // Core strobes are only meaningful here; elsewhere they are ignored.
                if (core_output_valid) begin
                    w_core_done = 1'b1;
                    w_state_nxt = r_last ? S_DONE : S_IDLE;
                end
`ifdef SHA256_SEQ_WDOG_EN
                else if (r_wdog_cnt == c_WDOG_W'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                if (dig_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h          <= IV;
            r_m          <= '0;
            r_last       <= 1'b0;
            r_msg_active <= 1'b0;
            r_dig        <= '0;
`ifdef SHA256_SEQ_WDOG_EN
            r_wdog_cnt   <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_m          <= blk_data;
                r_last       <= blk_last;
                r_msg_active <= 1'b1;
                // A new first block abandons any chain in progress.
                if (blk_first || !r_msg_active) begin
                    r_h <= IV;
                end
            end
            if (w_core_done) begin
                r_h <= core_H_out;
                if (r_last) begin
                    r_dig        <= core_H_out;
                    r_msg_active <= 1'b0;
                end
            end
`ifdef SHA256_SEQ_WDOG_EN
            r_err <= w_timeout;
            if (r_state == S_LOAD) begin
                r_wdog_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_msg_active <= 1'b0;
                r_h          <= IV;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_seq.sv
// Testbench for sha256_msg_seq with a behavioural 64-cycle SHA-256 core model.
`default_nettype none

module tb_sha256_msg_seq;

    localparam logic [255:0] IV    = 256'h6A09E667BB67AE853C6EF372A54FF53A510E527F9B05688C1F83D9AB5BE0CD19;
    localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B1    = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
    localparam logic [511:0] B2    = {480'h0, 32'h000001c0};
    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_2B  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         blk_first = 1'b0;
    logic         blk_last = 1'b0;
    logic         dig_valid;
    logic         dig_ready = 1'b0;
    logic [255:0] dig_data;
    logic         busy;
    logic [255:0] core_H_in;
    logic [511:0] core_M_in;
    logic         core_input_valid;
    logic [255:0] core_H_out;
    logic         core_output_valid;
`ifdef SHA256_SEQ_WDOG_EN
    logic         err;
`endif

    int errors = 0;
    int checks = 0;
    logic [255:0] sb [$];

    always #5 clk = ~clk;

    sha256_msg_seq dut (
        .clk(clk), .rst(rst),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
        .busy(busy),
        .core_H_in(core_H_in), .core_M_in(core_M_in), .core_input_valid(core_input_valid),
        .core_H_out(core_H_out), .core_output_valid(core_output_valid)
`ifdef SHA256_SEQ_WDOG_EN
        , .err(err)
`endif
    );

    // ---------------- SHA-256 core model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    logic [6:0]   m_cnt = '0;
    logic [255:0] m_h = '0;
    logic         suppress = 1'b0;
    logic         spur = 1'b0;
    logic [255:0] spur_h = '0;

    // Load sampled at the end of the LOAD cycle; done strobe 63 edges later.
    always_ff @(posedge clk) begin
        if (core_input_valid) begin
            m_cnt <= 7'd1;
            m_h   <= sha_compress(core_H_in, core_M_in);
        end else if (m_cnt == 7'd64) begin
            m_cnt <= '0;
        end else if (m_cnt != 7'd0) begin
            m_cnt <= m_cnt + 7'd1;
        end
    end

    assign core_output_valid = ((m_cnt == 7'd64) && !suppress) || spur;
    assign core_H_out        = spur ? spur_h : m_h;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic send_block(input logic [511:0] d, input logic f, input logic l, output bit ok);
        int n = 0;
        while (!blk_ready && n < 300) begin @(negedge clk); n++; end
        ok = blk_ready;
        if (ok) begin
            blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
            @(negedge clk);
            blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
        end
    endtask

    task automatic wait_digest(input int start, output int idx, output bit ok);
        idx = start;
        while (!dig_valid && idx < start + 300) begin @(negedge clk); idx++; end
        ok = dig_valid;
    endtask

    task automatic take_digest(output logic [255:0] d);
        d = dig_data;
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (blk_ready !== 1'b0) begin errors++; $display("FAIL reset_blk_ready: got %b want 0", blk_ready); end
        checks++; if (dig_valid !== 1'b0) begin errors++; $display("FAIL reset_dig_valid: got %b want 0", dig_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (core_input_valid !== 1'b0) begin errors++; $display("FAIL reset_civ: got %b want 0", core_input_valid); end
        checks++; if (dig_data !== 256'h0) begin errors++; $display("FAIL reset_dig_data: got %h want 0", dig_data); end
        checks++; if (core_H_in !== IV) begin errors++; $display("FAIL reset_h: got %h want %h", core_H_in, IV); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (blk_ready !== 1'b1) begin errors++; $display("FAIL idle_blk_ready: got %b want 1", blk_ready); end
    endtask

    task automatic test_abc;
        bit ok; int idx; logic [255:0] d, exp;
        send_block(ABC, 1'b1, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abc_accept: got no blk_ready want accept"); end
        sb.push_back(D_ABC);
        checks++; if (core_input_valid !== 1'b1) begin errors++; $display("FAIL abc_load_strobe: got %b want 1", core_input_valid); end
        checks++; if (core_M_in !== ABC) begin errors++; $display("FAIL abc_core_m: got %h want %h", core_M_in, ABC); end
        checks++; if (core_H_in !== IV) begin errors++; $display("FAIL abc_core_h: got %h want %h", core_H_in, IV); end
        @(negedge clk);
        checks++; if (core_input_valid !== 1'b0) begin errors++; $display("FAIL abc_strobe_width: got %b want 0", core_input_valid); end
        wait_digest(2, idx, ok);
        checks++; if (idx != 66) begin errors++; $display("FAIL abc_latency: got %0d want 66", idx); end
        take_digest(d);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (d !== exp) begin errors++; $display("FAIL abc_digest: got %h want %h", d, exp); end
        checks++; if (dig_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abc_after_handshake: got dv=%b rdy=%b busy=%b want 0 1 0", dig_valid, blk_ready, busy); end
    endtask

    task automatic test_two_block;
        bit ok, saw_dv; int idx; logic [255:0] d, exp;
        send_block(B1, 1'b1, 1'b0, ok);
        idx = 1; saw_dv = 1'b0;
        while (!blk_ready && idx < 300) begin
            if (dig_valid) saw_dv = 1'b1;
            @(negedge clk); idx++;
        end
        checks++; if (idx != 66) begin errors++; $display("FAIL two_blk_ready_low: got ready at cycle %0d want 66", idx); end
        checks++; if (saw_dv !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL two_mid_msg: got dv_seen=%b busy=%b want 0 1", saw_dv, busy); end
        send_block(B2, 1'b0, 1'b1, ok);
        sb.push_back(D_2B);
        checks++; if (core_H_in === IV) begin errors++; $display("FAIL two_chain: got %h want chained value", core_H_in); end
        wait_digest(1, idx, ok);
        checks++; if (idx != 66) begin errors++; $display("FAIL two_latency: got %0d want 66", idx); end
        take_digest(d);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (d !== exp) begin errors++; $display("FAIL two_digest: got %h want %h", d, exp); end
    endtask

    task automatic test_backpressure;
        bit ok; int idx; int bad; logic [255:0] d, exp;
        send_block(ABC, 1'b1, 1'b1, ok);
        sb.push_back(D_ABC);
        wait_digest(1, idx, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_dig_valid: got 0 want 1"); end
        bad = 0;
        repeat (10) begin
            if (dig_valid !== 1'b1 || dig_data !== D_ABC || blk_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
        take_digest(d);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (d !== exp) begin errors++; $display("FAIL bp_digest: got %h want %h", d, exp); end
        checks++; if (dig_valid !== 1'b0 || blk_ready !== 1'b1) begin
            errors++; $display("FAIL bp_complete: got dv=%b rdy=%b want 0 1", dig_valid, blk_ready); end
    endtask

    task automatic test_spurious;
        bit ok; int idx; logic [255:0] d, exp;
        spur_h = {8{$urandom()}};
        spur = 1'b1; @(negedge clk); spur = 1'b0; @(negedge clk);
        checks++; if (busy !== 1'b0 || blk_ready !== 1'b1) begin
            errors++; $display("FAIL spur_idle_state: got busy=%b rdy=%b want 0 1", busy, blk_ready); end
        checks++; if (core_H_in !== D_ABC || dig_data !== D_ABC) begin
            errors++; $display("FAIL spur_idle_regs: got h=%h dig=%h want %h", core_H_in, dig_data, D_ABC); end
        send_block(ABC, 1'b1, 1'b1, ok);
        sb.push_back(D_ABC);
        wait_digest(1, idx, ok);
        spur_h = ~spur_h;
        spur = 1'b1; @(negedge clk); spur = 1'b0;
        checks++; if (dig_valid !== 1'b1 || dig_data !== D_ABC || core_H_in !== D_ABC) begin
            errors++; $display("FAIL spur_done: got dv=%b dig=%h h=%h want 1 %h", dig_valid, dig_data, core_H_in, D_ABC); end
        take_digest(d);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (d !== exp) begin errors++; $display("FAIL spur_digest1: got %h want %h", d, exp); end
        send_block(ABC, 1'b1, 1'b1, ok);
        sb.push_back(D_ABC);
        wait_digest(1, idx, ok);
        take_digest(d);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (d !== exp) begin errors++; $display("FAIL spur_digest2: got %h want %h", d, exp); end
    endtask

    task automatic test_reset_in_wait;
        bit ok; int idx; logic [255:0] d, exp;
        send_block(B1, 1'b1, 1'b0, ok);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (blk_ready !== 1'b0 || dig_valid !== 1'b0 || core_input_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstw_ctrl: got rdy=%b dv=%b civ=%b busy=%b want 0 0 0 0",
                                blk_ready, dig_valid, core_input_valid, busy); end
        checks++; if (dig_data !== 256'h0 || core_H_in !== IV) begin
            errors++; $display("FAIL rstw_regs: got dig=%h h=%h want 0 %h", dig_data, core_H_in, IV); end
        rst = 1'b0;
        @(negedge clk);
        send_block(ABC, 1'b1, 1'b1, ok);
        sb.push_back(D_ABC);
        wait_digest(1, idx, ok);
        checks++; if (idx != 66) begin errors++; $display("FAIL rstw_latency: got %0d want 66", idx); end
        take_digest(d);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++; if (d !== exp) begin errors++; $display("FAIL rstw_digest: got %h want %h", d, exp); end
    endtask

`ifdef SHA256_SEQ_WDOG_EN
    task automatic test_watchdog;
        bit ok; int idx;
        suppress = 1'b1;
        send_block(ABC, 1'b1, 1'b1, ok);
        idx = 1;
        while (err !== 1'b1 && idx < 300) begin @(negedge clk); idx++; end
        checks++; if (idx != 82) begin errors++; $display("FAIL wdog_time: got err at cycle %0d want 82", idx); end
        checks++; if (busy !== 1'b0 || blk_ready !== 1'b1) begin
            errors++; $display("FAIL wdog_state: got busy=%b rdy=%b want 0 1", busy, blk_ready); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wdog_pulse: got %b want 0", err); end
        suppress = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_backpressure();
        test_spurious();
        test_reset_in_wait();
`ifdef SHA256_SEQ_WDOG_EN
        test_watchdog();
`endif
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
